lsu_mem_stage: RTL and testbench

- Memory stage directly downstream of the execute ALU in the pd5 pipeline.
- Consumes the ALU result, either as a load/store effective address or as a pass-through result.
- Drives a req/gnt/rvalid data-memory port and produces byte enables, store-lane replication, load-lane extraction and sign/zero extension.
- Delivers one writeback pulse per accepted op; a multi-cycle FSM stalls execute through in_ready.

---
 rtl/lsu_mem_stage_if.sv | 42 ++++
 rtl/lsu_mem_stage.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - execute, data-memory and writeback signals of the memory stage
interface lsu_mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] alu_result;
  logic [31:0]       store_data;
  logic              is_load;
  logic              is_store;
  logic [2:0]        funct3;
  logic [4:0]        rd;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              wb_exc;

  // master: execute stage plus memory model; slave: the memory stage itself
  modport master (
    output in_valid, alu_result, store_data, is_load, is_store, funct3, rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_rd, wb_data, wb_exc
  );

  modport slave (
    input  in_valid, alu_result, store_data, is_load, is_store, funct3, rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_rd, wb_data, wb_exc
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store memory stage with req/gnt/rvalid port and one writeback pulse per op
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  lsu_mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                wb_valid_q;
  logic                wb_exc_q;
  logic [4:0]          wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [1:0]          lane_q;
  logic [2:0]          funct3_q;
  logic [4:0]          rd_q;

  logic                accept;
  logic                is_mem;
  logic                exc_d;
  logic [3:0]          be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   lane_data;
  logic [DATA_W-1:0]   load_data_d;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign is_mem = bus.is_load || bus.is_store;

  // funct3[1:0] is the access size: 00 byte, 01 half, 10 word
  always_comb begin
    exc_d = 1'b0;
    if (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111)
      exc_d = 1'b1;
    else if (bus.funct3[1:0] == 2'b01 && bus.alu_result[0])
      exc_d = 1'b1;
    else if (bus.funct3[1:0] == 2'b10 && bus.alu_result[1:0] != 2'b00)
      exc_d = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.store_data;
    case (bus.funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << bus.alu_result[1:0];
        wdata_d = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {bus.alu_result[1], 1'b0};
        wdata_d = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_data = bus.mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_data_d = lane_data;
    case (funct3_q)
      3'b000:  load_data_d = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b100:  load_data_d = {24'd0, lane_data[7:0]};
      3'b001:  load_data_d = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b101:  load_data_d = {16'd0, lane_data[15:0]};
      default: load_data_d = lane_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_exc_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      rd_q        <= 5'd0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_exc_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= bus.alu_result;
              wb_rd_q    <= bus.rd;
            end else if (exc_d) begin
              wb_valid_q <= 1'b1;
              wb_exc_q   <= 1'b1;
              wb_rd_q    <= 5'd0;
              wb_data_q  <= bus.alu_result;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.is_store;
              mem_addr_q  <= {bus.alu_result[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              lane_q      <= bus.alu_result[1:0];
              funct3_q    <= bus.funct3;
              rd_q        <= bus.rd;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= load_data_d;
            wb_rd_q    <= rd_q;
            state_q    <= IDLE;
          end
        end
        DONE: begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= 5'd0;
          wb_data_q  <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_exc    = wb_exc_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;

  lsu_mem_stage_if #(.ADDR_W(32)) bus ();

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.alu_result = 32'd0;
    bus.store_data = 32'd0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.funct3     = 3'b000;
    bus.rd         = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] sd, input logic ld,
                       input logic st, input logic [2:0] f3, input logic [4:0] r);
    bus.in_valid   = 1'b1;
    bus.alu_result = a;
    bus.store_data = sd;
    bus.is_load    = ld;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.rd         = r;
  endtask

  // accept, gnt immediately, rvalid the cycle after gnt, then check the writeback
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [4:0] r, input logic [3:0] be, input logic [31:0] rdata,
                         input logic [31:0] exp);
    offer(a, 32'd0, 1'b1, 1'b0, f3, r);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    chk({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, bus.mem_be}, {28'd0, be});
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, "_wbv"}, {31'd0, bus.wb_valid}, 32'd1);
    chk({tag, "_data"}, bus.wb_data, exp);
    chk({tag, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, r});
    chk({tag, "_exc"}, {31'd0, bus.wb_exc}, 32'd0);
  endtask

  task automatic do_exc(input string tag, input logic [31:0] a, input logic ld,
                        input logic st, input logic [2:0] f3);
    offer(a, 32'h1111_2222, ld, st, f3, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, bus.wb_valid}, 32'd1);
    chk({tag, "_exc"}, {31'd0, bus.wb_exc}, 32'd1);
    chk({tag, "_rd"}, {27'd0, bus.wb_rd}, 32'd0);
    chk({tag, "_data"}, bus.wb_data, a);
    chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    idle_inputs();
    #3;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wbdata", bus.wb_data, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // non-memory op, latency 1
    offer(32'h0000_1234, 32'd0, 1'b0, 1'b0, 3'b000, 5'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("alu_wbv", {31'd0, bus.wb_valid}, 32'd1);
    chk("alu_data", bus.wb_data, 32'h0000_1234);
    chk("alu_rd", {27'd0, bus.wb_rd}, 32'd5);
    chk("alu_exc", {31'd0, bus.wb_exc}, 32'd0);
    chk("alu_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("alu_pulse", {31'd0, bus.wb_valid}, 32'd0);

    // back-to-back non-memory ops
    offer(32'h0000_0011, 32'd0, 1'b0, 1'b0, 3'b000, 5'd1);
    tick();
    chk("b2b_a", bus.wb_data, 32'h0000_0011);
    offer(32'h0000_0022, 32'd0, 1'b0, 1'b0, 3'b000, 5'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_bv", {31'd0, bus.wb_valid}, 32'd1);
    chk("b2b_b", bus.wb_data, 32'h0000_0022);
    chk("b2b_brd", {27'd0, bus.wb_rd}, 32'd2);
    tick();
    chk("b2b_end", {31'd0, bus.wb_valid}, 32'd0);

    // SB to 0x103, gnt after two wait cycles
    offer(32'h0000_0103, 32'hAABB_CCDD, 1'b0, 1'b1, 3'b000, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_req%0d", i), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("sb_we%0d", i), {31'd0, bus.mem_we}, 32'd1);
      chk($sformatf("sb_addr%0d", i), bus.mem_addr, 32'h0000_0100);
      chk($sformatf("sb_be%0d", i), {28'd0, bus.mem_be}, 32'h8);
      chk($sformatf("sb_wdata%0d", i), bus.mem_wdata, 32'hDDDD_DDDD);
      chk($sformatf("sb_rdy%0d", i), {31'd0, bus.in_ready}, 32'd0);
      if (i == 2) bus.mem_gnt = 1'b1;
      tick();
    end
    bus.mem_gnt = 1'b0;
    chk("sb_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("sb_done_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("sb_done_rdy", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("sb_wbv", {31'd0, bus.wb_valid}, 32'd1);
    chk("sb_wbrd", {27'd0, bus.wb_rd}, 32'd0);
    chk("sb_wbdata", bus.wb_data, 32'd0);
    chk("sb_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();

    // SH and SW lane patterns
    offer(32'h0000_0106, 32'h1234_5678, 1'b0, 1'b1, 3'b001, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("sh_be", {28'd0, bus.mem_be}, 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'h5678_5678);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    chk("sh_wbv", {31'd0, bus.wb_valid}, 32'd1);
    offer(32'h0000_0108, 32'h1234_5678, 1'b0, 1'b1, 3'b010, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("sw_be", {28'd0, bus.mem_be}, 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("sw_addr", bus.mem_addr, 32'h0000_0108);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    chk("sw_wbv", {31'd0, bus.wb_valid}, 32'd1);

    // loads with lane extraction and extension
    do_load("lb", 32'h0000_0202, 3'b000, 5'd6, 4'b0100, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0202, 3'b100, 5'd6, 4'b0100, 32'h0080_0000, 32'h0000_0080);
    do_load("lhu", 32'h0000_0202, 3'b101, 5'd8, 4'b1100, 32'h8001_0000, 32'h0000_8001);
    do_load("lh", 32'h0000_0202, 3'b001, 5'd8, 4'b1100, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lbpos", 32'h0000_0201, 3'b000, 5'd10, 4'b0010, 32'h0000_7F00, 32'h0000_007F);
    do_load("lw_rd0", 32'h0000_0300, 3'b010, 5'd0, 4'b1111, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // misaligned and illegal memory ops
    do_exc("lw_mis", 32'h0000_0301, 1'b1, 1'b0, 3'b010);
    do_exc("ill011", 32'h0000_0400, 1'b1, 1'b0, 3'b011);
    do_exc("sh_mis", 32'h0000_0401, 1'b0, 1'b1, 3'b001);
    tick();

    // LW with immediate gnt and delayed rvalid; a new op waits in WAIT
    offer(32'h0000_0500, 32'd0, 1'b1, 1'b0, 3'b010, 5'd3);
    tick();
    bus.mem_gnt = 1'b1;
    offer(32'h0000_0077, 32'd0, 1'b0, 1'b0, 3'b000, 5'd4);
    chk("dly_rdy_req", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dly_rdy%0d", i), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("dly_wbv%0d", i), {31'd0, bus.wb_valid}, 32'd0);
      if (i == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    chk("dly_wbv", {31'd0, bus.wb_valid}, 32'd1);
    chk("dly_data", bus.wb_data, 32'h1234_5678);
    chk("dly_rd", {27'd0, bus.wb_rd}, 32'd3);
    chk("dly_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("dly_next_wbv", {31'd0, bus.wb_valid}, 32'd1);
    chk("dly_next_data", bus.wb_data, 32'h0000_0077);
    chk("dly_next_rd", {27'd0, bus.wb_rd}, 32'd4);
    tick();

    // reset during REQ aborts; stray rvalid afterwards is ignored
    offer(32'h0000_0600, 32'h0000_0005, 1'b0, 1'b1, 3'b010, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("ab_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ab_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("ab_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    reset_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("ab_stray0", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    chk("ab_stray1", {31'd0, bus.wb_valid}, 32'd0);
    chk("ab_idle_req", {31'd0, bus.mem_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
